// File: rtl/rob_multi_commit.sv
// rob_multi_commit
//   Reorder buffer that retires instructions in program order. It has DEPTH
//   entries, WB_PORTS writeback channels and retires up to COMMIT_W entries
//   per cycle. A branch that was mispredicted is detected when it retires.
//   That retire redirects fetch and discards every younger entry.
// Ports
//   clk, rst               clock; synchronous active-high reset
//   rdy                    global enable. State is frozen and pulse outputs
//                          are masked while it is low.
//   issue_*                allocate at tail; issue_ready / issue_idx go back
//                          to the issue unit
//   q_idx1/2 -> q_ok/q_val operand lookup, combinational, with bypass from
//                          writebacks in the same cycle
//   wb_*                   packed per-port writeback (value/taken/target).
//                          For a store, value is the address and target is
//                          the data.
//   cm_*                   registered per-slot retire report
//   st_go/st_addr/st_data  release of the store at the head to memory
//   flush/redirect_pc      mispredict flush pulse and new fetch pc
module rob_multi_commit #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = 4,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    output logic [IDX_W-1:0]             issue_idx,
    input  logic [4:0]                   issue_rd,
    input  logic                         issue_br,
    input  logic                         issue_pred,
    input  logic                         issue_store,
    input  logic [31:0]                  issue_pc,
    input  logic [IDX_W-1:0]             q_idx1,
    input  logic [IDX_W-1:0]             q_idx2,
    output logic                         q_ok1,
    output logic                         q_ok2,
    output logic [31:0]                  q_val1,
    output logic [31:0]                  q_val2,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
    input  logic [WB_PORTS*32-1:0]       wb_value,
    input  logic [WB_PORTS-1:0]          wb_taken,
    input  logic [WB_PORTS*32-1:0]       wb_target,
    output logic [COMMIT_W-1:0]          cm_valid,
    output logic [COMMIT_W*5-1:0]        cm_rd,
    output logic [COMMIT_W*32-1:0]       cm_value,
    output logic [COMMIT_W*IDX_W-1:0]    cm_idx,
    output logic                         st_go,
    output logic [31:0]                  st_addr,
    output logic [31:0]                  st_data,
    output logic                         flush,
    output logic [31:0]                  redirect_pc
);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic        br;
        logic        pred;
        logic        store;
        logic [31:0] pc;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] ready;
    logic [IDX_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [COMMIT_W-1:0]       cm_valid_q;
    logic                      st_go_q, flush_q;

    logic [IDX_W-1:0] wb_idx_a    [WB_PORTS];
    logic [31:0]      wb_value_a  [WB_PORTS];
    logic [31:0]      wb_target_a [WB_PORTS];

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_unpack
        assign wb_idx_a[p]    = wb_idx[p*IDX_W +: IDX_W];
        assign wb_value_a[p]  = wb_value[p*32 +: 32];
        assign wb_target_a[p] = wb_target[p*32 +: 32];
    end

    logic issue_fire;
    assign issue_ready = (count != CNT_W'(DEPTH)) && !flush_q;
    assign issue_fire  = issue_valid && issue_ready;
    assign issue_idx   = tail;

    // Retire scan. The group stops at the first entry that is not ready, at
    // a mispredicted branch, or after a store. A store may only occupy slot
    // 0, so at most one store leaves per cycle and it leaves alone.
    logic [COMMIT_W-1:0] go;
    logic [IDX_W-1:0]    slot_idx [COMMIT_W];
    logic [CNT_W-1:0]    retire_n;
    logic                mis_any;
    logic [31:0]         redir_pc;
    logic                chain_open;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave a latch.
        chain_open = 1'b1;
        go         = '0;
        retire_n   = '0;
        mis_any    = 1'b0;
        redir_pc   = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k] = head + IDX_W'(k);
            if (chain_open && (CNT_W'(k) < count) && ready[slot_idx[k]] &&
                (!mem[slot_idx[k]].store || k == 0)) begin
                go[k]    = 1'b1;
                retire_n = retire_n + CNT_W'(1);
                if (mem[slot_idx[k]].store)
                    chain_open = 1'b0;
                if (mem[slot_idx[k]].br && (mem[slot_idx[k]].taken != mem[slot_idx[k]].pred)) begin
                    mis_any    = 1'b1;
                    chain_open = 1'b0;
                    redir_pc   = mem[slot_idx[k]].taken ? mem[slot_idx[k]].target
                                                        : mem[slot_idx[k]].pc + 32'd4;
                end
            end else begin
                chain_open = 1'b0;
            end
        end
    end

    // Pointer, count and ready-bit state. A mispredict drops this cycle's
    // issue and writebacks along with everything that is already buffered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ready <= '0;
        end else if (rdy) begin
            if (mis_any) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                ready <= '0;
            end else begin
                if (issue_fire) begin
                    ready[tail] <= 1'b0;
                    tail        <= tail + IDX_W'(1);
                end
                for (int p = 0; p < WB_PORTS; p++)
                    if (wb_valid[p])
                        ready[wb_idx_a[p]] <= 1'b1;
                head  <= head + retire_n[IDX_W-1:0];
                count <= count + CNT_W'(issue_fire) - retire_n;
            end
        end
    end

    // NOTE: entry payload has no reset; the ready bits and count gate every use of it.
    // Ports are applied in ascending order, so when two ports hit the same
    // index in one cycle the higher-numbered port wins.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !mis_any) begin
            if (issue_fire) begin
                mem[tail].rd    <= issue_rd;
                mem[tail].br    <= issue_br;
                mem[tail].pred  <= issue_pred;
                mem[tail].store <= issue_store;
                mem[tail].pc    <= issue_pc;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p]) begin
                    mem[wb_idx_a[p]].value  <= wb_value_a[p];
                    mem[wb_idx_a[p]].taken  <= wb_taken[p];
                    mem[wb_idx_a[p]].target <= wb_target_a[p];
                end
            end
        end
    end

    // Registered retire report. A retired store reports rd=0 so the
    // register file writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            cm_valid_q  <= '0;
            cm_rd       <= '0;
            cm_value    <= '0;
            cm_idx      <= '0;
            st_go_q     <= 1'b0;
            st_addr     <= '0;
            st_data     <= '0;
            flush_q     <= 1'b0;
            redirect_pc <= '0;
        end else if (rdy) begin
            cm_valid_q <= go;
            st_go_q    <= go[0] && mem[head].store;
            flush_q    <= mis_any;
            if (mis_any)
                redirect_pc <= redir_pc;
            if (go[0] && mem[head].store) begin
                st_addr <= mem[head].value;
                st_data <= mem[head].target;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                cm_rd[k*5 +: 5]          <= mem[slot_idx[k]].store ? 5'd0 : mem[slot_idx[k]].rd;
                cm_value[k*32 +: 32]     <= mem[slot_idx[k]].value;
                cm_idx[k*IDX_W +: IDX_W] <= slot_idx[k];
            end
        end
    end

    // Pulses are masked while rdy is low; the registers keep their state.
    assign cm_valid = cm_valid_q & {COMMIT_W{rdy}};
    assign st_go    = st_go_q & rdy;
    assign flush    = flush_q & rdy;

    // Operand lookup. A stored result takes priority. Otherwise the value
    // is bypassed from the lowest-numbered port writing that index.
    logic [IDX_W-1:0] q_idx_a [2];
    logic             q_ok_a  [2];
    logic [31:0]      q_val_a [2];

    assign q_idx_a[0] = q_idx1;
    assign q_idx_a[1] = q_idx2;

    always_comb begin
        for (int q = 0; q < 2; q++) begin
            q_ok_a[q]  = ready[q_idx_a[q]];
            q_val_a[q] = ready[q_idx_a[q]] ? mem[q_idx_a[q]].value : 32'd0;
            if (!ready[q_idx_a[q]]) begin
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_valid[p] && (wb_idx_a[p] == q_idx_a[q])) begin
                        q_ok_a[q]  = 1'b1;
                        q_val_a[q] = wb_value_a[p];
                    end
                end
            end
        end
    end

    assign q_ok1  = q_ok_a[0];
    assign q_ok2  = q_ok_a[1];
    assign q_val1 = q_val_a[0];
    assign q_val2 = q_val_a[1];

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit
//   Directed bench for rob_multi_commit using the default parameters
//   (DEPTH 16, two writeback ports, two commit slots). Each scenario starts
//   from reset. Expected values are worked out by hand from the intended
//   cycle behaviour.
module tb_rob_multi_commit;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_idx;
    logic [4:0]  issue_rd;
    logic        issue_br, issue_pred, issue_store;
    logic [31:0] issue_pc;
    logic [3:0]  q_idx1, q_idx2;
    logic        q_ok1, q_ok2;
    logic [31:0] q_val1, q_val2;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_idx;
    logic [63:0] wb_value;
    logic [1:0]  wb_taken;
    logic [63:0] wb_target;
    logic [1:0]  cm_valid;
    logic [9:0]  cm_rd;
    logic [63:0] cm_value;
    logic [7:0]  cm_idx;
    logic        st_go;
    logic [31:0] st_addr, st_data;
    logic        flush;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    rob_multi_commit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_idx(issue_idx),
        .issue_rd(issue_rd), .issue_br(issue_br), .issue_pred(issue_pred),
        .issue_store(issue_store), .issue_pc(issue_pc),
        .q_idx1(q_idx1), .q_idx2(q_idx2), .q_ok1(q_ok1), .q_ok2(q_ok2),
        .q_val1(q_val1), .q_val2(q_val2),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value), .cm_idx(cm_idx),
        .st_go(st_go), .st_addr(st_addr), .st_data(st_data),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_rd = '0; issue_br = 1'b0; issue_pred = 1'b0;
        issue_store = 1'b0; issue_pc = '0;
        q_idx1 = '0; q_idx2 = '0;
        wb_valid = '0; wb_idx = '0; wb_value = '0; wb_taken = '0; wb_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One issue cycle; the tail index given out is checked before the edge.
    task automatic do_issue(input logic [3:0] exp_idx, input logic [4:0] rd, input logic br,
                            input logic pred, input logic st, input logic [31:0] pc);
        issue_valid = 1'b1; issue_rd = rd; issue_br = br; issue_pred = pred;
        issue_store = st; issue_pc = pc;
        check("issue_idx", issue_idx, exp_idx);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic wb_set(input int p, input logic [3:0] idx, input logic [31:0] val,
                          input logic taken, input logic [31:0] tgt);
        wb_valid[p]         = 1'b1;
        wb_idx[p*4 +: 4]    = idx;
        wb_value[p*32 +: 32] = val;
        wb_taken[p]         = taken;
        wb_target[p*32 +: 32] = tgt;
    endtask

    task automatic wb_clear();
        wb_valid = '0; wb_idx = '0; wb_value = '0; wb_taken = '0; wb_target = '0;
    endtask

    initial begin
        do_reset();
        // Reset state
        check("rst_issue_ready", issue_ready, 1);
        check("rst_issue_idx", issue_idx, 0);
        check("rst_cm_valid", cm_valid, 0);
        check("rst_st_go", st_go, 0);
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect_pc, 0);

        // Fill all 16 entries, then retire one and check that the tail wraps to 0
        for (int i = 0; i < 16; i++)
            do_issue(4'(i), 5'(i + 1), 1'b0, 1'b0, 1'b0, 32'(i * 4));
        check("full_not_ready", issue_ready, 0);
        wb_set(0, 4'd0, 32'h100, 1'b0, 32'h0);
        tick();
        wb_clear();
        tick();
        check("fill_cm_valid", cm_valid, 2'b01);
        check("fill_cm_value", cm_value[31:0], 32'h100);
        check("fill_cm_idx", cm_idx[3:0], 0);
        check("fill_ready_again", issue_ready, 1);
        do_issue(4'd0, 5'd20, 1'b0, 1'b0, 1'b0, 32'h40);
        check("wrap_full_again", issue_ready, 0);

        // Out-of-order writeback: C, then B, then A; A and B retire together, C after
        do_reset();
        do_issue(4'd0, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0);
        do_issue(4'd1, 5'd2, 1'b0, 1'b0, 1'b0, 32'h4);
        do_issue(4'd2, 5'd3, 1'b0, 1'b0, 1'b0, 32'h8);
        wb_set(0, 4'd2, 32'hC, 1'b0, 32'h0); tick(); wb_clear();
        check("ooo_no_retire_c", cm_valid, 0);
        wb_set(0, 4'd1, 32'hB, 1'b0, 32'h0); tick(); wb_clear();
        check("ooo_no_retire_b", cm_valid, 0);
        wb_set(0, 4'd0, 32'hA, 1'b0, 32'h0); tick(); wb_clear();
        check("ooo_latency", cm_valid, 0);
        tick();
        check("ooo_ab_valid", cm_valid, 2'b11);
        check("ooo_ab_rd", cm_rd, {5'd2, 5'd1});
        check("ooo_ab_value", cm_value, {32'hB, 32'hA});
        check("ooo_ab_idx", cm_idx, {4'd1, 4'd0});
        check("ooo_no_st_go", st_go, 0);
        tick();
        check("ooo_c_valid", cm_valid, 2'b01);
        check("ooo_c_rd", cm_rd[4:0], 5'd3);
        check("ooo_c_value", cm_value[31:0], 32'hC);
        tick();
        check("ooo_idle", cm_valid, 0);

        // Lookup: same-cycle bypass from port 1, then the stored value after the edge
        do_reset();
        for (int i = 0; i < 4; i++)
            do_issue(4'(i), 5'(i + 1), 1'b0, 1'b0, 1'b0, 32'(i * 4));
        q_idx1 = 4'd3; q_idx2 = 4'd2;
        wb_set(1, 4'd3, 32'hDEAD_BEEF, 1'b0, 32'h0);
        #1;
        check("lookup_bypass_ok", q_ok1, 1);
        check("lookup_bypass_val", q_val1, 32'hDEAD_BEEF);
        check("lookup_miss_ok", q_ok2, 0);
        check("lookup_miss_val", q_val2, 0);
        tick();
        wb_clear();
        #1;
        check("lookup_stored_ok", q_ok1, 1);
        check("lookup_stored_val", q_val1, 32'hDEAD_BEEF);

        // A store at the head leaves alone; the ALU op behind it retires next cycle
        do_reset();
        do_issue(4'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h40);
        do_issue(4'd1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h44);
        wb_set(1, 4'd0, 32'h8000, 1'b0, 32'h1234);
        wb_set(0, 4'd1, 32'h55, 1'b0, 32'h0);
        tick();
        wb_clear();
        tick();
        check("st_go", st_go, 1);
        check("st_addr", st_addr, 32'h8000);
        check("st_data", st_data, 32'h1234);
        check("st_cm_valid", cm_valid, 2'b01);
        check("st_cm_rd_zero", cm_rd[4:0], 0);
        tick();
        check("st_alu_valid", cm_valid, 2'b01);
        check("st_alu_rd", cm_rd[4:0], 5'd5);
        check("st_alu_value", cm_value[31:0], 32'h55);
        check("st_go_pulse", st_go, 0);

        // Mispredict (pred 0, taken 1): the younger ready entry and a same-cycle issue are dropped
        do_reset();
        do_issue(4'd0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h100);
        do_issue(4'd1, 5'd2, 1'b0, 1'b0, 1'b0, 32'h104);
        wb_set(0, 4'd0, 32'h104, 1'b1, 32'h1000);
        wb_set(1, 4'd1, 32'h77, 1'b0, 32'h0);
        tick();
        wb_clear();
        issue_valid = 1'b1; issue_rd = 5'd3; issue_pc = 32'h108;
        wb_set(1, 4'd1, 32'h99, 1'b0, 32'h0);
        tick();
        clear_inputs();
        check("mis_flush", flush, 1);
        check("mis_redirect", redirect_pc, 32'h1000);
        check("mis_cm_valid", cm_valid, 2'b01);
        check("mis_link", cm_value[31:0], 32'h104);
        check("mis_issue_blocked", issue_ready, 0);
        check("mis_tail_reset", issue_idx, 0);
        tick();
        q_idx1 = 4'd1;
        #1;
        check("mis_flush_pulse", flush, 0);
        check("mis_younger_dropped", cm_valid, 0);
        check("mis_ready_cleared", q_ok1, 0);
        check("mis_issue_ready", issue_ready, 1);

        // Mispredict (pred 1, taken 0) behind an ALU op, with rdy held low before the retire edge
        do_reset();
        do_issue(4'd0, 5'd4, 1'b0, 1'b0, 1'b0, 32'h1FC);
        do_issue(4'd1, 5'd1, 1'b1, 1'b1, 1'b0, 32'h200);
        wb_set(0, 4'd0, 32'h44, 1'b0, 32'h0);
        wb_set(1, 4'd1, 32'h204, 1'b0, 32'h999);
        tick();
        wb_clear();
        rdy = 1'b0;
        q_idx1 = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rdy0_cm_valid", cm_valid, 0);
            check("rdy0_flush", flush, 0);
        end
        check("rdy0_lookup_ok", q_ok1, 1);
        check("rdy0_lookup_val", q_val1, 32'h44);
        rdy = 1'b1;
        tick();
        check("nt_cm_valid", cm_valid, 2'b11);
        check("nt_cm_rd", cm_rd, {5'd1, 5'd4});
        check("nt_cm_value", cm_value, {32'h204, 32'h44});
        check("nt_flush", flush, 1);
        check("nt_redirect", redirect_pc, 32'h204);
        rdy = 1'b0;
        tick();
        check("nt_rdy0_flush_masked", flush, 0);
        check("nt_rdy0_redirect_held", redirect_pc, 32'h204);
        rdy = 1'b1;
        tick();
        check("nt_flush_done", flush, 0);
        check("nt_issue_ready", issue_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
